mem_port_arbiter: RTL and testbench

// - Shares the single-ported unified Memoria between two requesters:
//   the CPU datapath (fetch and load/store) and a DMA/loader port.
// - Sits between the multicycle datapath's address mux and Memoria.
// - Sequences each access over a fixed memory latency and returns ack plus read data.
// - Drives cpu_stall so Unidade_de_Controle holds its state while an access is pending.

---
 rtl/mem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - CPU/DMA arbiter for the single-ported unified Memoria
//
// Purpose: shares one single-ported memory between the CPU datapath and a
// DMA/loader port. Each access is registered onto mem_* in IDLE and held for
// MEM_LAT cycles. In the last of those cycles the read data is captured and a
// one-cycle ack is raised. The CPU wins when both ports request, until it has
// taken STARVE_MAX grants in a row while DMA waited.
//
// Optional feature: define DMA_LOCK_EN to honour dma_lock. A DMA ack with
// dma_lock=1 keeps the grant on the DMA port until a DMA ack with dma_lock=0.
//
// Ports:
//   clock, reset             rising-edge clock, asynchronous active-low reset
//   cpu_req/wr/addr/wdata    CPU request, held until cpu_ack
//   cpu_ack, cpu_rdata       completion pulse and read data
//   cpu_stall                cpu_req & ~cpu_ack, holds the control unit
//   dma_req/wr/addr/wdata    DMA request, held until dma_ack
//   dma_lock                 burst lock (DMA_LOCK_EN builds only)
//   dma_ack, dma_rdata       completion pulse and read data
//   mem_addr/wr/wdata        to Memoria
//   mem_rdata                from Memoria
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_wr,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int STK_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC} state_t;

  state_t             state;
  logic [LAT_W-1:0]   lat_cnt;
  logic [STK_W-1:0]   streak;
  logic               acc_wr;
  logic               lock_active;
  logic               starve;
  logic               grant_cpu;
  logic               grant_dma;
  logic               lat_last;

`ifdef DMA_LOCK_EN
  logic lock_hold;
  assign lock_active = lock_hold;
`else
  logic unused_dma_lock;
  assign unused_dma_lock = dma_lock;
  assign lock_active     = 1'b0;
`endif

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign starve    = (streak == STK_W'(STARVE_MAX));
  // DMA wins when it is alone, when the CPU streak is exhausted, or while locked.
  // A held lock shuts the CPU out even if DMA momentarily has no request.
  assign grant_dma = dma_req & (lock_active | ~cpu_req | starve);
  assign grant_cpu = cpu_req & ~grant_dma & ~lock_active;
  assign lat_last  = (lat_cnt == LAT_W'(MEM_LAT - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      streak    <= '0;
      acc_wr    <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
      mem_addr  <= '0;
      mem_wr    <= 1'b0;
      mem_wdata <= '0;
`ifdef DMA_LOCK_EN
      lock_hold <= 1'b0;
`endif
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      // Write strobe lasts exactly the first access cycle.
      mem_wr  <= 1'b0;
      case (state)
        IDLE: begin
          lat_cnt <= '0;
          if (grant_cpu) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_wr    <= cpu_wr;
            acc_wr    <= cpu_wr;
            state     <= CPU_ACC;
            if (!dma_req)
              streak <= '0;
            else if (!starve)
              streak <= streak + STK_W'(1);
          end else if (grant_dma) begin
            mem_addr  <= dma_addr;
            mem_wdata <= dma_wdata;
            mem_wr    <= dma_wr;
            acc_wr    <= dma_wr;
            state     <= DMA_ACC;
            streak    <= '0;
          end
        end
        CPU_ACC, DMA_ACC: begin
          if (lat_last) begin
            lat_cnt <= '0;
            state   <= IDLE;
            if (state == CPU_ACC) begin
              cpu_ack <= 1'b1;
              if (!acc_wr) cpu_rdata <= mem_rdata;
            end else begin
              dma_ack <= 1'b1;
              if (!acc_wr) dma_rdata <= mem_rdata;
`ifdef DMA_LOCK_EN
              lock_hold <= dma_lock;
`endif
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int LAT  = 3;
  localparam int SMAX = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 0, cpu_wr = 0, dma_req = 0, dma_wr = 0, dma_lock = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dma_addr = 0, dma_wdata = 0;
  logic        cpu_ack, cpu_stall, dma_ack, mem_wr;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] last    [2];
  logic [31:0] cpu_q [$];
  logic [31:0] dma_q [$];
  int          ord_q [$];
  int          tests = 0, fails = 0;
  int          cyc = 0, last_ack = -100, wr_cycles = 0;
  int          ack_cyc [2];

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] init_val(input int i);
    return (i == 16) ? 32'hDEADBEEF : 32'hA5000000 + i * 32'h00010203;
  endfunction

  // Memoria: address held by the arbiter, so an asynchronous read suits any latency.
  assign mem_rdata = mem[mem_addr[5:0]];
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = init_val(i);
    forever begin
      @(posedge clock);
      if (mem_wr) mem[mem_addr[5:0]] <= mem_wdata;
    end
  end

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  task automatic check_ack(input int p);
    logic [31:0] e;
    if ((p == 0 && cpu_q.size() == 0) || (p == 1 && dma_q.size() == 0)) begin
      chk(p == 0 ? "spurious_cpu_ack" : "spurious_dma_ack", 1, 0);
      return;
    end
    e = (p == 0) ? cpu_q.pop_front() : dma_q.pop_front();
    chk(p == 0 ? "cpu_rdata" : "dma_rdata", p == 0 ? cpu_rdata : dma_rdata, e);
    chk("ack_spacing_ok", (cyc - last_ack) >= 1 + LAT, 1);
    if (ord_q.size() > 0) chk("grant_order", p, ord_q.pop_front());
    last_ack   = cyc;
    ack_cyc[p] = cyc;
  endtask

  // Monitor: compares every ack against the scoreboard queues.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (mem_wr) wr_cycles++;
      if (cpu_ack && dma_ack) chk("ack_overlap", 1, 0);
      if (cpu_ack) check_ack(0);
      if (dma_ack) check_ack(1);
    end
  end

  // Issues one access from a negedge, records the expectation, waits for the ack
  // and returns on the following negedge with req still high.
  task automatic acc(input int p, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic lk, output int lat);
    if (p == 0) begin
      cpu_req = 1; cpu_wr = wr; cpu_addr = a; cpu_wdata = d;
    end else begin
      dma_req = 1; dma_wr = wr; dma_addr = a; dma_wdata = d; dma_lock = lk;
    end
    if (wr) ref_mem[a[5:0]] = d;
    else    last[p] = ref_mem[a[5:0]];
    if (p == 0) cpu_q.push_back(last[0]);
    else        dma_q.push_back(last[1]);
    lat = 0;
    do begin
      @(posedge clock);
      #1;
      lat++;
    end while (!(p == 0 ? cpu_ack : dma_ack) && lat < 200);
    if (p == 0) begin
      chk("cpu_ack_seen", cpu_ack, 1);
      chk("cpu_stall_at_ack", cpu_stall, 0);
    end else begin
      chk("dma_ack_seen", dma_ack, 1);
    end
    @(negedge clock);
  endtask

  task automatic drop(input int p);
    if (p == 0) cpu_req = 0;
    else        dma_req = 0;
  endtask

  task automatic rand_port(input int p);
    int          l;
    logic [31:0] a;
    for (int k = 0; k < 20; k++) begin
      a = (p == 1) ? 32'h20 + $urandom_range(0, 15) : 32'($urandom_range(0, 15));
      acc(p, 1'($urandom_range(0, 1)), a, $urandom, 1'b0, l);
      if ($urandom_range(0, 2) == 0) begin
        drop(p);
        repeat ($urandom_range(1, 4)) @(negedge clock);
      end
    end
    drop(p);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ctl"}, {cpu_ack, dma_ack, mem_wr, cpu_stall}, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_rdata"}, {cpu_rdata, dma_rdata}, 0);
  endtask

  initial begin
    int l;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    last[0] = 0; last[1] = 0;
    #1 reset = 0;
    repeat (2) @(negedge clock);
    #1 check_zero("reset");
    @(negedge clock);
    reset = 1;
    @(negedge clock);

    // CPU read of 0x10 with an uncontended port.
    fork
      acc(0, 0, 32'h10, 0, 0, l);
      begin
        #1 chk("cpu_stall_pending", cpu_stall, 1);
        @(posedge clock);
        #2 chk("mem_addr_granted", mem_addr, 32'h10);
        chk("mem_wr_on_read", mem_wr, 0);
      end
    join
    cpu_req = 0;
    chk("cpu_read_latency", l, 1 + LAT);
    chk("cpu_rdata_deadbeef", cpu_rdata, 32'hDEADBEEF);

    // DMA write then CPU read-back of the same word.
    wr_cycles = 0;
    acc(1, 1, 32'h20, 32'h12345678, 0, l);
    dma_req = 0;
    chk("dma_write_latency", l, 1 + LAT);
    chk("mem_wr_cycles", wr_cycles, 1);
    chk("dma_rdata_kept_on_write", dma_rdata, 0);
    acc(0, 0, 32'h20, 0, 0, l);
    cpu_req = 0;
    chk("cpu_readback", cpu_rdata, 32'h12345678);

    // Simultaneous single requests from idle.
    ord_q = '{0, 1};
    fork
      begin acc(0, 0, 32'h05, 0, 0, l); cpu_req = 0; end
      begin acc(1, 0, 32'h25, 0, 0, l); dma_req = 0; end
    join
    chk("dma_after_cpu_gap", ack_cyc[1] - ack_cyc[0], 1 + LAT);
    chk("order_drained_simul", ord_q.size(), 0);

    // Both ports held continuously: four CPU grants per DMA grant.
    ord_q = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    fork
      begin
        for (int k = 0; k < 8; k++) acc(0, 0, 32'(k), 0, 0, l);
        cpu_req = 0;
      end
      begin
        acc(1, 1, 32'h2A, 32'hCAFE0001, 0, l);
        acc(1, 0, 32'h2A, 0, 0, l);
        dma_req = 0;
      end
    join
    chk("order_drained_starve", ord_q.size(), 0);

    // DMA burst with lock, CPU requesting from the second cycle on.
`ifdef DMA_LOCK_EN
    ord_q = '{1, 1, 1, 0};
`else
    ord_q = '{1, 0, 1, 1};
`endif
    fork
      begin
        acc(1, 0, 32'h22, 0, 1, l);
        acc(1, 0, 32'h23, 0, 1, l);
        acc(1, 0, 32'h24, 0, 0, l);
        dma_req = 0; dma_lock = 0;
      end
      begin
        @(posedge clock);
        @(negedge clock);
        acc(0, 0, 32'h11, 0, 0, l);
        cpu_req = 0;
      end
    join
    chk("order_drained_lock", ord_q.size(), 0);

    // Randomised concurrent traffic on disjoint address regions.
    fork
      rand_port(0);
      rand_port(1);
    join
    repeat (2) @(negedge clock);
    chk("cpu_q_empty", cpu_q.size(), 0);
    chk("dma_q_empty", dma_q.size(), 0);

    // Reset in the middle of a DMA read: the access is dropped without an ack.
    dma_req = 1; dma_wr = 0; dma_addr = 32'h21;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 0; dma_req = 0;
    #1 check_zero("midreset");
    last[0] = 0; last[1] = 0; last_ack = -100;
    repeat (3) @(negedge clock);
    reset = 1;
    @(negedge clock);
    acc(0, 0, 32'h10, 0, 0, l);
    cpu_req = 0;
    chk("post_reset_latency", l, 1 + LAT);
    chk("post_reset_rdata", cpu_rdata, 32'hDEADBEEF);
    repeat (2 * (1 + LAT)) @(negedge clock);
    chk("no_late_dma_ack", dma_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
